noc_pkt_tx: RTL and testbench

NOC_PKT_TX -- requirements
Module: noc_pkt_tx

---
 rtl/noc_pkt_tx.sv | 215 +++++++++++++++++++++
 tb/tb_noc_pkt_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pkt_tx.sv
// noc_pkt_tx: serialises READ/WRITE commands into byte packets on the NoC
// to-device link. A write-payload byte FIFO feeds the DATA phase.
//
// Packet on tod_ctl/tod_data: HDR(ctl=1, {alen,dlen,op}), DEST, SRC,
// 2^alen address bytes (LSB first), then 2^dlen payload bytes for WRITE.
// NOP (ctl=1, data=0) is driven while idle and during the inter-packet gap.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op/alen/dlen       opcode (1=READ, 2=WRITE), log2 addr/data byte counts
//   cmd_dest/cmd_src       device IDs (00 and FF are illegal)
//   cmd_addr               64-bit address
//   wdat_valid/ready/wdat  payload byte stream into the FIFO
//   tod_ctl/tod_data       registered link outputs
//   busy                   packet in flight (HDR..DATA)
//   pkt_done               pulse with the last byte of a packet
//   cmd_err                pulse after an illegal command was dropped
module noc_pkt_tx #(
   parameter int FIFO_DEPTH = 128,
   parameter int NOP_GAP    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  cmd_alen,
   input  logic [2:0]  cmd_dlen,
   input  logic [7:0]  cmd_dest,
   input  logic [7:0]  cmd_src,
   input  logic [63:0] cmd_addr,
   input  logic        wdat_valid,
   output logic        wdat_ready,
   input  logic [7:0]  wdat,
   output logic        tod_ctl,
   output logic [7:0]  tod_data,
   output logic        busy,
   output logic        pkt_done,
   output logic        cmd_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_DEST = 3'd2;
   localparam logic [2:0] S_SRC  = 3'd3;
   localparam logic [2:0] S_ADDR = 3'd4;
   localparam logic [2:0] S_DATA = 3'd5;
   localparam logic [2:0] S_GAP  = 3'd6;

   // Gap counter shares the 8-bit byte counter, so NOP_GAP is limited to 256.
   localparam logic [7:0] GAP_LAST = 8'(NOP_GAP - 1);

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  alen;
      logic [2:0]  dlen;
      logic [7:0]  dest;
      logic [7:0]  src;
      logic [63:0] addr;
   } cmd_t;

   cmd_t cmd_in, cmd_q;

   logic [2:0]    state, nxt_state;
   logic [7:0]    cnt, nxt_cnt;
   logic [7:0]    alen_last, dlen_last;
   logic          is_write;
   logic          accept, legal;
   logic [CW:0]   need;

   logic          nxt_ctl, nxt_done, pop, push;
   logic [7:0]    nxt_data;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] fifo_count;

   assign cmd_in = {cmd_op, cmd_alen, cmd_dlen, cmd_dest, cmd_src, cmd_addr};

   // WRITE is only offered a ready once its whole payload is buffered, which
   // guarantees the DATA phase never pops an empty FIFO.
   assign need      = {{CW{1'b0}}, 1'b1} << cmd_dlen;
   assign cmd_ready = !reset && (state == S_IDLE) &&
                      ((cmd_op != 3'd2) || ({1'b0, fifo_count} >= need));
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = ((cmd_op == 3'd1) || (cmd_op == 3'd2)) &&
                      (cmd_dest != 8'h00) && (cmd_dest != 8'hFF) &&
                      (cmd_src  != 8'h00) && (cmd_src  != 8'hFF);

   assign alen_last = (8'd1 << cmd_q.alen) - 8'd1;
   assign dlen_last = (8'd1 << cmd_q.dlen) - 8'd1;
   assign is_write  = (cmd_q.op == 3'd2);

   assign busy       = (state != S_IDLE) && (state != S_GAP);
   assign wdat_ready = (fifo_count < CW'(FIFO_DEPTH));
   assign push       = wdat_valid && wdat_ready;

   // state/cnt always describe the byte currently on the link
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      case (state)
         S_IDLE: if (accept && legal) nxt_state = S_HDR;
         S_HDR:  nxt_state = S_DEST;
         S_DEST: nxt_state = S_SRC;
         S_SRC: begin
            nxt_state = S_ADDR;
            nxt_cnt   = 8'd0;
         end
         S_ADDR: begin
            if (cnt != alen_last) begin
               nxt_cnt = cnt + 8'd1;
            end else if (is_write) begin
               nxt_state = S_DATA;
               nxt_cnt   = 8'd0;
            end else begin
               nxt_state = (NOP_GAP > 0) ? S_GAP : S_IDLE;
               nxt_cnt   = 8'd0;
            end
         end
         S_DATA: begin
            if (cnt != dlen_last) begin
               nxt_cnt = cnt + 8'd1;
            end else begin
               nxt_state = (NOP_GAP > 0) ? S_GAP : S_IDLE;
               nxt_cnt   = 8'd0;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               nxt_state = S_IDLE;
               nxt_cnt   = 8'd0;
            end else begin
               nxt_cnt = cnt + 8'd1;
            end
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = 8'd0;
         end
      endcase
   end

   // Link byte for the state being entered; registered on the same edge.
   // HDR is only entered from IDLE on acceptance, so it uses the live inputs.
   always_comb begin
      nxt_ctl  = 1'b1;
      nxt_data = 8'h00;
      nxt_done = 1'b0;
      pop      = 1'b0;
      case (nxt_state)
         S_HDR:  nxt_data = {cmd_in.alen, cmd_in.dlen, cmd_in.op};
         S_DEST: begin
            nxt_ctl  = 1'b0;
            nxt_data = cmd_q.dest;
         end
         S_SRC: begin
            nxt_ctl  = 1'b0;
            nxt_data = cmd_q.src;
         end
         S_ADDR: begin
            nxt_ctl  = 1'b0;
            nxt_data = cmd_q.addr[{nxt_cnt[2:0], 3'b000} +: 8];
            nxt_done = !is_write && (nxt_cnt == alen_last);
         end
         S_DATA: begin
            nxt_ctl  = 1'b0;
            nxt_data = fifo_mem[rd_ptr];
            nxt_done = (nxt_cnt == dlen_last);
            pop      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 8'd0;
         cmd_q      <= '0;
         tod_ctl    <= 1'b1;
         tod_data   <= 8'h00;
         pkt_done   <= 1'b0;
         cmd_err    <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         tod_ctl  <= nxt_ctl;
         tod_data <= nxt_data;
         pkt_done <= nxt_done;
         cmd_err  <= accept && !legal;
         if (accept) cmd_q <= cmd_in;
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // storage needs no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wdat;
   end

endmodule

// File: tb/tb_noc_pkt_tx.sv
// Directed bench for noc_pkt_tx: expected link bytes are queued when a
// command is accepted and popped by a negedge monitor as the DUT emits them.
module tb_noc_pkt_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_alen;
   logic [2:0]  cmd_dlen;
   logic [7:0]  cmd_dest, cmd_src;
   logic [63:0] cmd_addr;
   logic        wdat_valid, wdat_ready;
   logic [7:0]  wdat;
   logic        tod_ctl;
   logic [7:0]  tod_data;
   logic        busy, pkt_done, cmd_err;

   always #5 clk = ~clk;

   noc_pkt_tx #(.FIFO_DEPTH(128), .NOP_GAP(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_alen(cmd_alen), .cmd_dlen(cmd_dlen),
      .cmd_dest(cmd_dest), .cmd_src(cmd_src), .cmd_addr(cmd_addr),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
      .tod_ctl(tod_ctl), .tod_data(tod_data),
      .busy(busy), .pkt_done(pkt_done), .cmd_err(cmd_err)
   );

   typedef struct {
      logic       ctl;
      logic [7:0] data;
      logic       last;
      logic       is_data;
      logic       first;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_q[$];
   int         occ = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   exp_t       me;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic ctl, input logic [7:0] d, input logic last,
                           input logic isd, input logic first);
      exp_t e;
      e.ctl = ctl; e.data = d; e.last = last; e.is_data = isd; e.first = first;
      exp_q.push_back(e);
   endtask

   // link monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_byte", 64'(exp_q.size() > 0), 64'd1);
            end else begin
               me = exp_q.pop_front();
               chk("link_byte", {tod_ctl, tod_data, pkt_done}, {me.ctl, me.data, me.last});
               if (me.is_data) occ--;
            end
         end else begin
            chk("nop", {busy, tod_ctl, tod_data, pkt_done}, {1'b0, 1'b1, 8'h00, 1'b0});
            if (exp_q.size() > 0) chk("no_gap", 64'(exp_q[0].first), 64'd1);
         end
      end
   end

   // called just after a posedge; returns just after a posedge
   task automatic push_bytes(input int n, input logic [7:0] start);
      for (int i = 0; i < n; i++) begin
         wdat_valid = 1'b1;
         wdat = start + 8'(i);
         @(negedge clk); #1;
         chk("wdat_ready", wdat_ready, 64'(occ < 128));
         if (occ < 128) begin
            model_q.push_back(wdat);
            occ++;
         end
         @(posedge clk); #1;
      end
      wdat_valid = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] alen, input logic [2:0] dlen,
                       input logic [7:0] dest, input logic [7:0] src, input logic [63:0] addr);
      bit         legal;
      int         n, na, nd;
      logic [7:0] hdr;
      legal = ((op == 3'd1) || (op == 3'd2)) && (dest != 8'h00) && (dest != 8'hFF) &&
              (src != 8'h00) && (src != 8'hFF);
      hdr = {alen, dlen, op};
      na = 1 << alen;
      nd = 1 << dlen;
      cmd_valid = 1'b1; cmd_op = op; cmd_alen = alen; cmd_dlen = dlen;
      cmd_dest = dest; cmd_src = src; cmd_addr = addr;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("cmd_accept_timeout", 64'(n < 300), 64'd1);
      if (n < 300 && legal) begin
         push_exp(1'b1, hdr, 1'b0, 1'b0, 1'b1);
         push_exp(1'b0, dest, 1'b0, 1'b0, 1'b0);
         push_exp(1'b0, src, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < na; k++)
            push_exp(1'b0, addr[8*k +: 8], (op == 3'd1) && (k == na - 1), 1'b0, 1'b0);
         if (op == 3'd2)
            for (int k = 0; k < nd; k++)
               push_exp(1'b0, model_q.pop_front(), k == nd - 1, 1'b1, 1'b0);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      if (legal) begin
         chk("hdr_latency", {busy, tod_ctl, tod_data}, {1'b1, 1'b1, hdr});
         chk("cmd_err_quiet", cmd_err, 64'd0);
      end else begin
         chk("cmd_err_pulse", cmd_err, 64'd1);
         chk("illegal_no_pkt", busy, 64'd0);
         @(negedge clk);
         chk("cmd_err_one_cycle", cmd_err, 64'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", 64'(n < 400), 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_alen = '0; cmd_dlen = '0;
      cmd_dest = '0; cmd_src = '0; cmd_addr = '0; wdat_valid = 1'b0; wdat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_link", {tod_ctl, tod_data}, {1'b1, 8'h00});
      chk("rst_busy", busy, 64'd0);
      chk("rst_done_err", {pkt_done, cmd_err}, 64'd0);
      chk("rst_cmd_ready", cmd_ready, 64'd0);
      chk("rst_fifo_count", dut.fifo_count, 64'd0);
      chk("rst_wdat_ready", wdat_ready, 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // READ alen=0 dlen=3: 19,05,01,00 then gap and idle
      send(3'd1, 2'd0, 3'd3, 8'h05, 8'h01, 64'h0);
      n = 0;
      @(negedge clk);
      while (pkt_done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("done_seen", 64'(n < 20), 64'd1);
      @(negedge clk);
      chk("gap_busy", busy, 64'd0);
      chk("gap_ready", cmd_ready, 64'd0);
      @(negedge clk);
      chk("idle_ready", cmd_ready, 64'd1);
      @(posedge clk); #1;
      wait_idle();

      // address byte order for wider addresses
      send(3'd1, 2'd3, 3'd0, 8'h7E, 8'h42, 64'h8877_6655_4433_2211);
      wait_idle();
      send(3'd1, 2'd2, 3'd5, 8'h10, 8'h20, 64'hDEAD_BEEF_CAFE_F00D);
      wait_idle();

      // WRITE alen=1 dlen=3 with 8 buffered bytes
      push_bytes(8, 8'h10);
      send(3'd2, 2'd1, 3'd3, 8'h22, 8'h33, 64'h0);
      wait_idle();
      chk("write8_fifo_empty", dut.fifo_count, 64'd0);

      // WRITE dlen=4 held off until the 16th byte arrives
      push_bytes(15, 8'h40);
      fork
         send(3'd2, 2'd0, 3'd4, 8'h11, 8'h12, 64'hAB);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk); #1;
               chk("ready_low_15", cmd_ready, 64'd0);
            end
            @(posedge clk); #1;
            push_bytes(1, 8'h4F);
            @(negedge clk); #1;
            chk("ready_16", cmd_ready, 64'd1);
         end
      join
      wait_idle();
      chk("write16_fifo_empty", dut.fifo_count, 64'd0);

      // illegal commands leave the FIFO untouched
      push_bytes(3, 8'h80);
      send(3'd1, 2'd0, 3'd0, 8'hFF, 8'h01, 64'h0);
      send(3'd5, 2'd0, 3'd0, 8'h05, 8'h01, 64'h0);
      send(3'd1, 2'd1, 3'd0, 8'h05, 8'h00, 64'h0);
      wait_idle();
      chk("illegal_fifo_kept", dut.fifo_count, 64'd3);

      // fill to 128, drop one extra, drain 128 while refilling (pointer wrap)
      push_bytes(125, 8'h83);
      push_bytes(1, 8'hAA);
      chk("full_wdat_ready", wdat_ready, 64'd0);
      chk("full_count", dut.fifo_count, 64'd128);
      fork
         send(3'd2, 2'd0, 3'd7, 8'h21, 8'h31, 64'h0);
         begin
            repeat (12) @(posedge clk);
            #1;
            push_bytes(20, 8'hC0);
         end
      join
      wait_idle();
      chk("leftover_20", dut.fifo_count, 64'd20);
      send(3'd2, 2'd0, 3'd4, 8'h44, 8'h55, 64'h0);
      wait_idle();
      chk("leftover_4", dut.fifo_count, 64'd4);

      // reset during DATA byte 3 aborts the packet
      push_bytes(8, 8'hD0);
      send(3'd2, 2'd0, 3'd3, 8'h66, 8'h77, 64'h0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      model_q.delete();
      occ = 0;
      @(negedge clk);
      chk("abort_link_nop", {tod_ctl, tod_data, pkt_done}, {1'b1, 8'h00, 1'b0});
      chk("abort_busy", busy, 64'd0);
      chk("abort_fifo_count", dut.fifo_count, 64'd0);
      chk("abort_cmd_ready", cmd_ready, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_no_resume", busy, 64'd0);
      @(posedge clk); #1;
      send(3'd1, 2'd1, 3'd0, 8'h09, 8'h0A, 64'h1234);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
